// File: rtl/alu_result_collector.sv
// alu_result_collector: buffers ALU results in a FIFO and handles irq edge detection, acknowledge and statistics
module alu_result_collector #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       capture_en,
    input  logic [7:0]                 alu_out,
    input  logic                       alu_irq,
    input  logic                       rd_en,
    output logic [8:0]                 rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       irq_pending,
    input  logic                       irq_ack,
    output logic                       irq_clear,
    output logic [CNT_W-1:0]           irq_count,
    input  logic                       clr_stats
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, PEND, CLR} irq_state_t;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop, alu_irq_d, irq_edge;
    irq_state_t    state, state_nxt;

    // A full FIFO still accepts a write when the same cycle frees a slot
    assign do_push  = capture_en & (~full | rd_en);
    assign do_pop   = rd_en & ~empty;
    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign irq_edge = alu_irq & ~alu_irq_d;

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= {alu_irq, alu_out};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(do_push);
            rd_ptr   <= rd_ptr + AW'(do_pop);
            count    <= count + CW'(do_push) - CW'(do_pop);
            rd_valid <= do_pop;
            if (do_pop) rd_data <= mem[rd_ptr];
            overflow <= ~clr_stats & (overflow | (capture_en & full & ~rd_en));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_irq_d <= 1'b0;
            irq_count <= '0;
            state     <= IDLE;
        end else begin
            alu_irq_d <= alu_irq;
            irq_count <= clr_stats ? '0 : irq_count + CNT_W'(irq_edge & (irq_count != '1));
            state     <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        state_nxt = (state == IDLE) ? (irq_edge ? PEND : IDLE) :
                    (state == PEND) ? (irq_ack ? CLR : PEND) :
                                      (irq_edge ? PEND : IDLE);
    end

    assign irq_pending = state == PEND;
    assign irq_clear   = state == CLR;
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: scoreboard bench for the FIFO path plus directed irq checks
module tb_alu_result_collector;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0, capture_en = 1'b0, rd_en = 1'b0, alu_irq = 1'b0;
    logic       irq_ack = 1'b0, clr_stats = 1'b0;
    logic [7:0] alu_out = '0;
    logic [8:0] rd_data, s_rd_data;
    logic       rd_valid, full, empty, overflow, irq_pending, irq_clear;
    logic       s_rd_valid, s_full, s_empty, s_overflow, s_irq_pending, s_irq_clear;
    logic [3:0] count, s_count;
    logic [7:0] irq_count;
    logic [1:0] s_irq_count;

    alu_result_collector #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .capture_en(capture_en), .alu_out(alu_out), .alu_irq(alu_irq),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .irq_pending(irq_pending), .irq_ack(irq_ack),
        .irq_clear(irq_clear), .irq_count(irq_count), .clr_stats(clr_stats)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation checks
    alu_result_collector #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .capture_en(capture_en), .alu_out(alu_out), .alu_irq(alu_irq),
        .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .count(s_count), .overflow(s_overflow), .irq_pending(s_irq_pending), .irq_ack(irq_ack),
        .irq_clear(s_irq_clear), .irq_count(s_irq_count), .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    int         checks = 0, errors = 0;
    logic [8:0] sb[$];
    logic [8:0] last = '0;
    int         mc = 0;
    logic       ovf_m = 1'b0;
    logic       irq_l = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic cap, input logic [7:0] d, input logic rd,
                        input logic ack = 1'b0, input logic clr = 1'b0, input logic r = 1'b0);
        logic pv, pu;
        @(negedge clk);
        rst = r; capture_en = cap; alu_out = d; alu_irq = irq_l; rd_en = rd; irq_ack = ack; clr_stats = clr;
        @(posedge clk);
        pv = 1'b0;
        if (r) begin
            sb.delete(); mc = 0; ovf_m = 1'b0; last = '0;
        end else begin
            pv = rd && mc > 0;
            pu = cap && (mc < DEPTH || rd);
            if (pv) last = sb.pop_front();
            if (pu) sb.push_back({irq_l, d});
            if (cap && mc == DEPTH && !rd) ovf_m = 1'b1;
            if (clr) ovf_m = 1'b0;
            mc = mc + int'(pu) - int'(pv);
        end
        #1;
        chk("rd_valid", rd_valid, pv);
        chk("rd_data", rd_data, last);
        chk("count", count, mc);
        chk("full", full, mc == DEPTH);
        chk("empty", empty, mc == 0);
        chk("overflow", overflow, ovf_m);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_pending", irq_pending, 0);
        chk("rst_clear", irq_clear, 0);
        chk("rst_irq_count", irq_count, 0);

        step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0);
        repeat (3) step(0, 0, 1);
        step(0, 0, 1);

        for (int i = 1; i <= 9; i++) step(1, 8'(i), 0);
        chk("full_after_9", full, 1);
        repeat (8) step(0, 0, 1);
        step(0, 0, 0);
        chk("ovf_sticky", overflow, 1);
        step(0, 0, 0, 0, 1);

        for (int i = 0; i < 8; i++) step(1, 8'h40 + 8'(i), 0);
        for (int i = 0; i < 16; i++) step(1, 8'h80 + 8'(i), 1);
        chk("wrap_count", count, 8);
        repeat (8) step(0, 0, 1);

        irq_l = 1'b1; step(0, 0, 0);
        chk("edge1_pending", irq_pending, 1);
        chk("edge1_count", irq_count, 1);
        irq_l = 1'b0; step(0, 0, 0);
        irq_l = 1'b1; step(0, 0, 0);
        chk("edge2_count", irq_count, 2);
        chk("edge2_pending", irq_pending, 1);
        irq_l = 1'b0; step(0, 0, 0, 1);
        chk("ack_clear", irq_clear, 1);
        chk("ack_pending", irq_pending, 0);
        step(0, 0, 0);
        chk("clear_one_cycle", irq_clear, 0);
        chk("idle_pending", irq_pending, 0);

        irq_l = 1'b1; step(0, 0, 0);
        chk("edge3_count", irq_count, 3);
        irq_l = 1'b0; step(0, 0, 0, 1);
        chk("clr_state", irq_clear, 1);
        irq_l = 1'b1; step(0, 0, 0);
        chk("edge_in_clr_pending", irq_pending, 1);
        chk("edge_in_clr_clear", irq_clear, 0);
        chk("edge_in_clr_count", irq_count, 4);
        chk("sat_count4", s_irq_count, 3);
        irq_l = 1'b0; step(0, 0, 0);
        irq_l = 1'b1; step(0, 0, 0);
        chk("edge5_count", irq_count, 5);
        chk("sat_count5", s_irq_count, 3);
        irq_l = 1'b0; step(0, 0, 0);
        irq_l = 1'b1; step(0, 0, 0, 0, 1);
        chk("clr_edge_count", irq_count, 0);
        chk("clr_edge_sat", s_irq_count, 0);
        step(0, 0, 0);
        chk("clr_hold", irq_count, 0);
        irq_l = 1'b0; step(0, 0, 0, 1);
        step(0, 0, 0);
        chk("back_idle", irq_pending, 0);

        irq_l = 1'b1; step(1, 8'hA1, 0);
        step(1, 8'hA2, 0); step(1, 8'hA3, 0); step(1, 8'hA4, 0);
        chk("pre_rst_pending", irq_pending, 1);
        chk("pre_rst_count", count, 4);
        irq_l = 1'b0; step(0, 0, 0, 0, 0, 1);
        chk("rst_mid_pending", irq_pending, 0);
        chk("rst_mid_clear", irq_clear, 0);
        step(0, 0, 0);
        chk("rst_no_clear", irq_clear, 0);
        chk("rst_mid_irq_count", irq_count, 0);
        step(0, 0, 1);
        step(1, 8'h5A, 1);
        step(0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Stage directly downstream of the 8-bit ALU.
- Captures each enabled ALU result together with its irq bit into a small FIFO, so a slower consumer can drain results.
- Edge-detects the ALU irq, tracks it through an acknowledge state machine, and drives the ALU's irq_clear input.
- Keeps a saturating irq event counter and a sticky overflow flag.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of irq_count.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- capture_en  in  1  ALU result valid this cycle; driven high by the control stage whenever the ALU is enabled.
- alu_out  in  8  ALU registered result.
- alu_irq  in  1  ALU registered irq.
- rd_en  in  1  consumer pop request.
- rd_data  out  9  popped entry, {irq, data[7:0]}.
- rd_valid  out  1  rd_data valid, one-cycle pulse.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a capture was dropped.
- irq_pending  out  1  an unacknowledged irq event exists.
- irq_ack  in  1  consumer acknowledges the pending irq.
- irq_clear  out  1  one-cycle pulse to the ALU irq_clear input.
- irq_count  out  CNT_W  number of irq rising edges, saturating.
- clr_stats  in  1  clears overflow and irq_count.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: rd_data=0, rd_valid=0, count=0, empty=1, full=0, overflow=0, irq_pending=0, irq_clear=0, irq_count=0.
  - Internal: pointers=0, irq FSM=IDLE, alu_irq_d=0.
  - Reset mid-operation discards all FIFO contents and any pending irq; no irq_clear is issued.
- Push:
  - A push occurs when capture_en=1 and (full=0, or rd_en=1 in the same cycle).
  - Entry written = {alu_irq, alu_out}, sampled at that edge.
- Overflow:
  - capture_en=1, full=1, rd_en=0: the entry is dropped and overflow is set.
  - overflow stays set until clr_stats or rst.
- Pop:
  - A pop occurs when rd_en=1 and empty=0.
  - rd_data and rd_valid are registered: the entry appears with rd_valid=1 on the cycle after rd_en.
  - rd_data holds its last value when rd_valid=0.
  - rd_en while empty=1 is ignored: no pulse, no underflow, pointers unchanged.
- Simultaneous push and pop:
  - count is unchanged. This holds when full, which is how a full FIFO accepts a write.
  - When empty, no write-through: the pop is ignored, the push lands, and empty drops next cycle.
- Flags and pointers:
  - count, full and empty update on the edge after the push or pop.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Irq edge detection:
  - alu_irq_d is alu_irq registered one cycle.
  - edge = alu_irq & ~alu_irq_d.
  - Edge detection is independent of capture_en.
- Irq counter:
  - irq_count increments on every edge and saturates at 2^CNT_W-1.
  - clr_stats takes priority over an edge in the same cycle: the result is 0.
- Irq FSM (registered, 3 states):
  - IDLE: edge -> PEND.
  - PEND: irq_pending=1. irq_ack -> CLR. Further edges are counted only.
  - CLR: irq_clear=1 for exactly this cycle, then -> IDLE. If an edge occurs during CLR, go -> PEND instead.
  - irq_ack is ignored in IDLE and CLR.
  - irq_pending = (state==PEND). irq_clear = (state==CLR).
- No combinational paths from inputs to outputs.

Test Plan:
- Reset, then push 0x11,0x22,0x33 (irq=0), then pop 3 times -> rd_data 0x011,0x022,0x033 each one cycle after its rd_en; empty=1 and count=0 after the last pop.
- Push 9 values 0x01..0x09 with DEPTH=8 and no reads -> full=1 after the 8th push; the 9th (0x09) is dropped and overflow=1; popping yields 0x01..0x08; overflow stays 1 until clr_stats.
- Fill to full, then hold capture_en=1 and rd_en=1 for 16 cycles with incrementing data -> count stays 8, overflow stays 0, pop order is correct across two pointer wraps.
- Drive alu_irq 0->1 -> irq_pending=1 and irq_count=1; a second edge while PEND -> count=2, still PEND; irq_ack -> irq_clear pulses exactly one cycle, then irq_pending=0.
- irq edge during the CLR cycle -> FSM returns to PEND (irq_pending=1) and irq_count increments; with CNT_W=2, 5 edges -> irq_count=3; clr_stats with a simultaneous edge -> irq_count=0.
- Assert rst for one cycle while FIFO holds 4 entries and irq is PEND -> next cycle empty=1, count=0, irq_pending=0, and no irq_clear pulse.
